// File: rtl/barrel_shifter_pipe_if.sv
// Operand/result handshake bundle for barrel_shifter_pipe.
// The operand source and result sink both use the master side; the shifter uses the slave side.
interface barrel_shifter_pipe_if #(
  parameter int WIDTH = 8
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_mode;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_carry
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_carry
  );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROR) with last-bit-out carry and valid/ready flow control.
// Shift level k moves the word by 2^k; LEVELS_PER_STAGE levels sit between each pair of registers.
module barrel_shifter_pipe #(
  parameter int WIDTH            = 8,
  parameter int LEVELS_PER_STAGE = 1
) (
  input logic                 clk,
  input logic                 clrn,
  barrel_shifter_pipe_if.slave bus
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int PIPE = (SHW + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
  localparam logic [WIDTH-1:0] ONES = '1;

  typedef enum logic [1:0] {
    MODE_LSL = 2'd0,
    MODE_LSR = 2'd1,
    MODE_ASR = 2'd2,
    MODE_ROR = 2'd3
  } mode_e;

  // Stage registers; index PIPE-1 drives the result port.
  logic [PIPE-1:0]  valid_q;
  logic [WIDTH-1:0] data_q [PIPE];
  logic [SHW-1:0]   amt_q  [PIPE];
  mode_e            mode_q [PIPE];
  logic [PIPE-1:0]  sign_q;
  logic [PIPE-1:0]  carry_q;

  // Values presented to each stage's level logic, and what it will register.
  logic [PIPE-1:0]  src_valid;
  logic [WIDTH-1:0] src_data [PIPE];
  logic [SHW-1:0]   src_amt  [PIPE];
  mode_e            src_mode [PIPE];
  logic [PIPE-1:0]  src_sign;
  logic [PIPE-1:0]  src_carry;

  logic [WIDTH-1:0] data_d [PIPE];
  logic [PIPE-1:0]  carry_d;
  logic [PIPE-1:0]  adv;

  // A stage moves when it is empty or its successor moves, so bubbles collapse.
  always_comb begin
    adv           = '0;
    adv[PIPE-1]   = !valid_q[PIPE-1] || bus.out_ready;
    for (int s = PIPE - 2; s >= 0; s--) begin
      adv[s] = !valid_q[s] || adv[s+1];
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves a value held and no latch is inferred.
    src_valid = '0;
    src_data  = '{default: '0};
    src_amt   = '{default: '0};
    src_mode  = '{default: MODE_LSL};
    src_sign  = '0;
    src_carry = '0;

    src_valid[0] = bus.in_valid;
    src_data[0]  = bus.in_data;
    src_amt[0]   = bus.in_amt;
    src_mode[0]  = mode_e'(bus.in_mode);
    src_sign[0]  = bus.in_data[WIDTH-1];
    src_carry[0] = 1'b0;

    for (int s = 1; s < PIPE; s++) begin
      src_valid[s] = valid_q[s-1];
      src_data[s]  = data_q[s-1];
      src_amt[s]   = amt_q[s-1];
      src_mode[s]  = mode_q[s-1];
      src_sign[s]  = sign_q[s-1];
      src_carry[s] = carry_q[s-1];
    end
  end

  always_comb begin : level_logic
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] tmp;
    logic [SHW-1:0]   amt_sh;
    logic             c;
    int               k;
    int               step;

    data_d  = '{default: '0};
    carry_d = '0;
    cur     = '0;
    tmp     = '0;
    amt_sh  = '0;
    c       = 1'b0;
    k       = 0;
    step    = 1;

    for (int s = 0; s < PIPE; s++) begin
      cur = src_data[s];
      c   = src_carry[s];
      for (int j = 0; j < LEVELS_PER_STAGE; j++) begin
        k      = s * LEVELS_PER_STAGE + j;
        amt_sh = src_amt[s] >> k;
        if (k < SHW && amt_sh[0]) begin
          step = 1 << k;
          // Levels run in increasing order, so the bit leaving at this level is
          // the last one lost so far; a later active level overwrites it.
          case (src_mode[s])
            MODE_LSL: begin
              tmp = cur >> (WIDTH - step);
              c   = tmp[0];
              cur = cur << step;
            end
            MODE_LSR: begin
              tmp = cur >> (step - 1);
              c   = tmp[0];
              cur = cur >> step;
            end
            MODE_ASR: begin
              tmp = cur >> (step - 1);
              c   = tmp[0];
              cur = (cur >> step) | (src_sign[s] ? ~(ONES >> step) : '0);
            end
            MODE_ROR: begin
              cur = (cur >> step) | (cur << (WIDTH - step));
              c   = cur[WIDTH-1];
            end
            default: begin
              cur = src_data[s];
              c   = src_carry[s];
            end
          endcase
        end
      end
      data_d[s]  = cur;
      carry_d[s] = c;
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every stage samples its predecessor's pre-edge value.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q <= '0;
      sign_q  <= '0;
      carry_q <= '0;
      // NOTE: these per-stage arrays are pipeline registers, not a RAM, so
      // clearing every entry on reset is intended and cheap.
      for (int s = 0; s < PIPE; s++) begin
        data_q[s] <= '0;
        amt_q[s]  <= '0;
        mode_q[s] <= MODE_LSL;
      end
    end else begin
      for (int s = 0; s < PIPE; s++) begin
        if (adv[s]) begin
          valid_q[s] <= src_valid[s];
          if (src_valid[s]) begin
            data_q[s]  <= data_d[s];
            amt_q[s]   <= src_amt[s];
            mode_q[s]  <= src_mode[s];
            sign_q[s]  <= src_sign[s];
            carry_q[s] <= carry_d[s];
          end
        end
      end
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = valid_q[PIPE-1];
  assign bus.out_data  = data_q[PIPE-1];
  assign bus.out_carry = carry_q[PIPE-1];

  a_stall_holds: assert property (@(posedge clk) disable iff (!clrn)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_carry)));

  a_full_blocks: assert property (@(posedge clk) disable iff (!clrn)
    (&valid_q && !bus.out_ready) |-> !bus.in_ready);

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe: arithmetic reference model with a
// scoreboard compare on every falling edge, plus directed vectors with literal results.
module tb_barrel_shifter_pipe;

  localparam int W    = 8;
  localparam int SHW  = 3;
  localparam int PIPE = 3;

  typedef struct {
    logic [W-1:0]   data;
    logic [SHW-1:0] amt;
    logic [1:0]     mode;
    int             acc;
    bit             seen;
    bit             has_lit;
    logic [W-1:0]   lit_data;
    logic           lit_carry;
  } op_t;

  logic clk;
  logic clrn;
  int   cyc;
  int   n_checks;
  int   n_pass;

  bit           strict;
  bit           rand_bp;
  bit           drv_has_lit;
  logic [W-1:0] drv_lit_data;
  logic         drv_lit_carry;

  op_t          sb[$];
  bit           prev_stall;
  logic [W-1:0] prev_data;
  logic         prev_carry;
  logic [W:0]   cmp_m;
  op_t          cmp_e;

  barrel_shifter_pipe_if #(.WIDTH(W)) bus ();

  barrel_shifter_pipe #(.WIDTH(W), .LEVELS_PER_STAGE(1)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: {carry, data} from plain arithmetic on the whole operand.
  function automatic logic [W:0] model(input logic [1:0] mode, input logic [SHW-1:0] amt,
                                       input logic [W-1:0] d);
    int           n;
    logic [W-1:0] r;
    logic [2*W-1:0] dd;
    logic         c;
    n = int'(amt);
    if (n == 0) return {1'b0, d};
    case (mode)
      2'd0: begin r = d << n; c = ((d >> (W - n)) & 8'h01) != 0; end
      2'd1: begin r = d >> n; c = ((d >> (n - 1)) & 8'h01) != 0; end
      2'd2: begin r = $signed(d) >>> n; c = ((d >> (n - 1)) & 8'h01) != 0; end
      default: begin dd = {d, d} >> n; r = dd[W-1:0]; c = r[W-1]; end
    endcase
    return {c, r};
  endfunction

  // Scoreboard compare: runs on every falling edge, owns the expected-result queue.
  always @(negedge clk or negedge clrn) begin
    if (!clrn) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready", bus.in_ready, (sb.size() == PIPE && !bus.out_ready) ? 0 : 1);
      if (prev_stall) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, prev_data);
        check("hold_carry", bus.out_carry, prev_carry);
      end
      if (sb.size() == 0) begin
        check("idle_out_valid", bus.out_valid, 0);
      end else if (bus.out_valid) begin
        cmp_m = model(sb[0].mode, sb[0].amt, sb[0].data);
        check("out_data", bus.out_data, cmp_m[W-1:0]);
        check("out_carry", bus.out_carry, cmp_m[W]);
        if (!sb[0].seen) begin
          check("latency_ok", strict ? (cyc - sb[0].acc == PIPE) : (cyc - sb[0].acc >= PIPE), 1);
          if (sb[0].has_lit) begin
            check("lit_data", bus.out_data, sb[0].lit_data);
            check("lit_carry", bus.out_carry, sb[0].lit_carry);
          end
          sb[0].seen = 1'b1;
        end
        if (bus.out_ready) void'(sb.pop_front());
      end else if (strict && (cyc - sb[0].acc >= PIPE)) begin
        check("late_out_valid", bus.out_valid, 1);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_carry = bus.out_carry;
      if (bus.in_valid && bus.in_ready) begin
        cmp_e.data      = bus.in_data;
        cmp_e.amt       = bus.in_amt;
        cmp_e.mode      = bus.in_mode;
        cmp_e.acc       = cyc;
        cmp_e.seen      = 1'b0;
        cmp_e.has_lit   = drv_has_lit;
        cmp_e.lit_data  = drv_lit_data;
        cmp_e.lit_carry = drv_lit_carry;
        sb.push_back(cmp_e);
      end
    end
  end

  task automatic send(input logic [1:0] mode, input logic [SHW-1:0] amt, input logic [W-1:0] data,
                      input bit has_lit, input logic [W-1:0] ld, input logic lc, output int waits);
    logic [W:0] m;
    bit         acc;
    if (has_lit) begin
      m = model(mode, amt, data);
      check("model_pin_data", m[W-1:0], ld);
      check("model_pin_carry", m[W], lc);
    end
    drv_has_lit   = has_lit;
    drv_lit_data  = ld;
    drv_lit_carry = lc;
    bus.in_valid  = 1'b1;
    bus.in_mode   = mode;
    bus.in_amt    = amt;
    bus.in_data   = data;
    waits = 0;
    acc   = 1'b0;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (!acc) waits++;
      if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
    end
    if (!acc) check("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
    bus.in_data  = W'($urandom);
    bus.in_amt   = SHW'($urandom);
    bus.in_mode  = 2'($urandom);
  endtask

  task automatic drain(input int budget);
    for (int t = 0; t < budget && sb.size() != 0; t++) begin
      @(posedge clk);
      #1;
      if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
    end
    check("drain_empty", sb.size(), 0);
  endtask

  logic [W-1:0] asr_exp [8];
  int           w;

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0;
    strict = 1'b0; rand_bp = 1'b0;
    drv_has_lit = 1'b0; drv_lit_data = '0; drv_lit_carry = 1'b0;
    asr_exp = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    clrn = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_amt = '0; bus.in_mode = '0;
    bus.out_ready = 1'b1;

    #3;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_carry", bus.out_carry, 0);
    #9 clrn = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", bus.in_ready, 1);

    // Basic modes, back to back, exact latency.
    strict = 1'b1;
    send(2'd0, 3'd3, 8'h96, 1, 8'hB0, 1'b0, w);
    send(2'd1, 3'd2, 8'h96, 1, 8'h25, 1'b1, w);
    send(2'd2, 3'd2, 8'h96, 1, 8'hE5, 1'b1, w);
    send(2'd3, 3'd3, 8'h96, 1, 8'hD2, 1'b1, w);
    drain(20);

    // Zero shift in every mode.
    for (int m = 0; m < 4; m++) send(2'(m), 3'd0, 8'h5A, 1, 8'h5A, 1'b0, w);
    drain(20);

    // Stream sweep: ASR 0x80 by 0..7 with no gaps.
    for (int a = 0; a < 8; a++) begin
      send(2'd2, 3'(a), 8'h80, 1, asr_exp[a], 1'b0, w);
      if (a > 0) check("stream_gap", w, 0);
    end
    drain(20);
    strict = 1'b0;

    // Backpressure: three fill the pipe, the fourth waits.
    bus.out_ready = 1'b0;
    send(2'd0, 3'd1, 8'h01, 1, 8'h02, 1'b0, w);
    send(2'd0, 3'd2, 8'h01, 1, 8'h04, 1'b0, w);
    send(2'd0, 3'd3, 8'h01, 1, 8'h08, 1'b0, w);
    bus.in_valid = 1'b1; bus.in_mode = 2'd0; bus.in_amt = 3'd4; bus.in_data = 8'h01;
    repeat (4) begin
      @(negedge clk);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_hold_first", bus.out_data, 8'h02);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(2'd0, 3'd4, 8'h01, 1, 8'h10, 1'b0, w);
    send(2'd0, 3'd5, 8'h01, 1, 8'h20, 1'b0, w);
    drain(30);

    // Bubble collapse: final stage stalled, two empty stages still fill.
    bus.out_ready = 1'b0;
    send(2'd3, 3'd1, 8'h01, 1, 8'h80, 1'b1, w);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("bubble_final_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    send(2'd1, 3'd7, 8'h80, 1, 8'h01, 1'b0, w);
    check("bubble_accept_b", w, 0);
    send(2'd0, 3'd7, 8'hFF, 1, 8'h80, 1'b1, w);
    check("bubble_accept_c", w, 0);
    @(negedge clk);
    check("bubble_full_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drain(30);

    // Reset with results in flight.
    send(2'd1, 3'd1, 8'hF0, 0, 8'h00, 1'b0, w);
    send(2'd0, 3'd2, 8'h33, 0, 8'h00, 1'b0, w);
    send(2'd3, 3'd5, 8'hA5, 0, 8'h00, 1'b0, w);
    check("pre_rst_out_valid", bus.out_valid, 1);
    #1 clrn = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", bus.out_data, 0);
    check("midrst_out_carry", bus.out_carry, 0);
    #1 clrn = 1'b1;
    #1;
    check("postrst_in_ready", bus.in_ready, 1);
    repeat (6) @(posedge clk);
    #1;
    check("postrst_no_stale", bus.out_valid, 0);

    // Randomised sweep of every mode and amount with random backpressure.
    rand_bp = 1'b1;
    for (int m = 0; m < 4; m++)
      for (int a = 0; a < 8; a++)
        for (int r = 0; r < 4; r++)
          send(2'(m), 3'(a), W'($urandom), 0, 8'h00, 1'b0, w);
    drain(2000);
    rand_bp = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
- Parametrised, pipelined barrel shifter: successor to the fixed 8-bit combinational shifter built from 4:1 mux cells.
- Shifts a WIDTH-bit word by 0..WIDTH-1 in one of four modes: logical left, logical right, arithmetic right, rotate right.
- Shift levels are split across registered pipeline stages, with valid/ready handshakes on input and output.
- Sits between an operand source (ALU front end / test harness) and a result sink that may apply backpressure.

Parameters:
- WIDTH, 8, data width; power of two, minimum 4.
- LEVELS_PER_STAGE, 1, shift levels (one 2:1 mux layer each) evaluated between pipeline registers; range 1..SHW.
- SHW (derived, localparam), log2(WIDTH), shift-amount width.
- PIPE (derived, localparam), ceil(SHW / LEVELS_PER_STAGE), pipeline depth and latency in cycles.

Ports:
- clk  input  1  clock; all registers update on rising edge.
- clrn  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_amt/in_mode are valid.
- in_ready  output  1  block can accept this cycle.
- in_data  input  WIDTH  operand.
- in_amt  input  SHW  shift amount.
- in_mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- out_valid  output  1  out_data/out_carry are valid.
- out_ready  input  1  sink accepts this cycle.
- out_data  output  WIDTH  shifted result.
- out_carry  output  1  last bit shifted out (see rules below).

Behaviour:
- Reset (clrn low, asynchronous):
  - All stage valid bits, data, amt, mode and carry registers clear to 0 immediately.
  - Result: out_valid=0, out_data=0, out_carry=0.
  - Any in-flight operations are discarded; no partial result is ever presented.
  - After release, in_ready=1.
- Transfers:
  - Input transfer occurs on a rising edge with in_valid & in_ready.
  - Output transfer occurs on a rising edge with out_valid & out_ready.
- Shift datapath:
  - Level k (k=0..SHW-1) shifts by 2^k when amt[k]=1, otherwise passes through.
  - Each stage evaluates LEVELS_PER_STAGE consecutive levels, starting at k=0, then registers the result.
  - Each stage carries amt, mode and a carry bit forward with the data.
- Fill rules per mode:
  - LSL and LSR: zero fill.
  - ASR: fill with the original operand MSB (in_data[WIDTH-1]), which is carried through the stages.
  - ROR: bits exiting at bit 0 re-enter at bit WIDTH-1.
- Carry rules, for amt n > 0:
  - LSL: in_data[WIDTH-n].
  - LSR and ASR: in_data[n-1].
  - ROR: out_data[WIDTH-1].
  - For n = 0: out_carry=0 and out_data=in_data in every mode.
- Latency and throughput:
  - Latency is exactly PIPE cycles from input transfer to out_valid when not stalled.
  - Throughput is one operation per cycle.
- Stall rules:
  - Stage i advances when it is empty or stage i+1 advances; the final stage advances when it is empty or out_ready=1.
  - in_ready = stage 0 empty, or stage 0 advancing. This is combinational from pipeline state and out_ready.
  - Bubbles collapse: an empty stage accepts new data even while a downstream stage is stalled.
  - While out_valid=1 and out_ready=0, out_data and out_carry hold stable.
  - With all PIPE stages full and out_ready=0, in_ready=0.
  - No operation is ever dropped, duplicated or reordered.
- Simultaneous events:
  - Input and output transfers in the same cycle with a full pipeline are legal and sustain full throughput.
- Input restrictions:
  - in_mode/in_amt/in_data are sampled only on an input transfer.
  - Values of these inputs while in_valid=0 have no effect.
- Implementation constraint: no latches; all combinational logic fully specified for all mode values.

Test Plan (WIDTH=8, LEVELS_PER_STAGE=1, PIPE=3):
1. Basic modes: send each of the following, out_ready=1; every result appears exactly 3 cycles after its input transfer.
   - LSL 0x96 amt 3 -> out_data 0xB0, carry 0.
   - LSR 0x96 amt 2 -> 0x25, carry 1.
   - ASR 0x96 amt 2 -> 0xE5, carry 1.
   - ROR 0x96 amt 3 -> 0xD2, carry 1.
2. Zero shift: 0x5A amt 0 in all four modes -> out_data 0x5A, carry 0 each time.
3. Streaming and sweep: back-to-back stream of 8 ops (ASR 0x80 amt 0..7), out_ready=1 -> out_valid high 8 consecutive cycles; outputs in order:
   - 0x80, 0xC0, 0xE0, 0xF0, 0xF8, 0xFC, 0xFE, 0xFF.
4. Backpressure: out_ready=0, offer 5 ops -> only 3 accepted and in_ready=0 from then on; out_data holds the first result. Then release out_ready -> all 5 results delivered in order, none lost or duplicated.
5. Bubble collapse: one op in final stage stalled, two empty stages -> 2 further ops accepted while stalled.
6. Reset mid-operation: 2 ops in flight, pulse clrn low between clock edges -> out_valid=0, out_data=0 immediately. After release: no stale result emerges and in_ready=1. Randomised sweep of all modes/amounts/data against a reference model with random out_ready -> zero mismatches.
